// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and FSM state types for the multiport register file
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    typedef enum logic {P_IDLE, P_ACK} probe_state_e;
    typedef enum logic {C_IDLE, C_RUN} clr_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-entry busy bits with one set port, three clear ports, a clear-all and NUM_RD lookups
module rf_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     clr_all,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [2:0]               clr_en,
    input  logic [3*ADDR_W-1:0]      clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] look_addr,
    output logic [NUM_RD-1:0]        look_busy
);
    logic [2**ADDR_W-1:0] busy;

    // set is applied last so a new producer outranks a same-cycle retirement
    always_ff @(posedge clk) begin
        if (clr_all) begin
            busy <= '0;
        end else begin
            for (int j = 0; j < 3; j++)
                if (clr_en[j]) busy[clr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_look
        assign look_busy[k] = busy[look_addr[k*ADDR_W +: ADDR_W]];
    end
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: NUM_RD-read / 2-write register file with scoreboard, debug probe and clear engine
// RF_BYPASS_EN: forwards same-cycle write data and busy release to matching read ports
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     probe_req,
    input  logic [ADDR_W-1:0]        probe_addr,
    output logic                     probe_ack,
    output logic [DATA_W-1:0]        probe_data,
    input  logic                     clr_req,
    output logic                     clr_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    probe_state_e      p_state, p_next;
    clr_state_e        c_state, c_next;
    logic [ADDR_W-1:0] cnt;
    logic              clr_run, we0, we1, iss;
    logic [NUM_RD-1:0] sb_busy;

    // the clear engine owns the array while running; entry 0 is immutable when hardwired
    assign clr_run  = c_state == C_RUN;
    assign clr_busy = clr_run;
    assign we0 = wr0_en && !clr_run && !(ZERO_REG != 0 && wr0_addr == '0);
    assign we1 = wr1_en && !clr_run && !(ZERO_REG != 0 && wr1_addr == '0);
    assign iss = iss_en && !clr_run && !(ZERO_REG != 0 && iss_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we1) mem[wr1_addr] <= wr1_data;
            if (we0) mem[wr0_addr] <= wr0_data;
            if (clr_run) mem[cnt] <= '0;
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
        .clk       (clk),
        .clr_all   (rst),
        .set_en    (iss),
        .set_addr  (iss_addr),
        .clr_en    ({clr_run, we1, we0}),
        .clr_addr  ({cnt, wr1_addr, wr0_addr}),
        .look_addr (rd_addr),
        .look_busy (sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        logic h0, h1;
        assign h0 = we0 && wr0_addr == a;
        assign h1 = we1 && wr1_addr == a;
        assign rd_data[k*DATA_W +: DATA_W] = h0 ? wr0_data : h1 ? wr1_data : mem[a];
        assign rd_busy[k] = (h0 || h1) ? (iss && iss_addr == a) : sb_busy[k];
`else
        assign rd_data[k*DATA_W +: DATA_W] = mem[a];
        assign rd_busy[k] = sb_busy[k];
`endif
    end

    always_comb begin
        p_next = (p_state == P_IDLE && probe_req) ? P_ACK : P_IDLE;
        c_next = clr_run ? (cnt == '1 ? C_IDLE : C_RUN) : (clr_req ? C_RUN : C_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_IDLE;
            c_state    <= C_IDLE;
            cnt        <= '0;
            probe_ack  <= 1'b0;
            probe_data <= '0;
        end else begin
            p_state   <= p_next;
            c_state   <= c_next;
            cnt       <= clr_run ? cnt + 1'b1 : '0;
            probe_ack <= p_state == P_ACK;
            if (p_state == P_ACK) probe_data <= mem[probe_addr];
        end
    end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed and random checks of rf_multiport against an array-based reference model
module tb_rf_multiport;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en, wr1_en, iss_en, probe_req, clr_req;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr, probe_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        probe_ack, clr_busy;
    logic [31:0] probe_data;

    rf_multiport dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .probe_req(probe_req), .probe_addr(probe_addr), .probe_ack(probe_ack), .probe_data(probe_data),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m [32];
    logic        b [32];
    int          clr_left;
    logic        inflight, e_ack;
    logic [31:0] e_pdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bypass_ok();
`ifdef RF_BYPASS_EN
        return clr_left == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (bypass_ok() && wr0_en && wr0_addr == a && a != 0) return wr0_data;
        if (bypass_ok() && wr1_en && wr1_addr == a && a != 0) return wr1_data;
        return m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (bypass_ok() && a != 0 && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)))
            return iss_en && iss_addr == a;
        return b[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m[i] = '0; b[i] = 1'b0; end
        clr_left = 0; inflight = 1'b0; e_ack = 1'b0; e_pdata = '0;
    endtask

    task automatic model_step();
        e_ack = inflight;
        if (inflight) e_pdata = m[probe_addr];
        inflight = probe_req && !inflight;
        if (clr_left > 0) begin
            m[32-clr_left] = '0; b[32-clr_left] = 1'b0; clr_left--;
        end else begin
            if (wr1_en && wr1_addr != 0) begin m[wr1_addr] = wr1_data; b[wr1_addr] = 1'b0; end
            if (wr0_en && wr0_addr != 0) begin m[wr0_addr] = wr0_data; b[wr0_addr] = 1'b0; end
            if (iss_en && iss_addr != 0) b[iss_addr] = 1'b1;
            if (clr_req) clr_left = 32;
        end
    endtask

    task automatic cycle();
        logic [4:0] a;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            chk($sformatf("rd_data%0d[r%0d]", k, a), rd_data[k*32 +: 32], exp_rd(a));
            chk($sformatf("rd_busy%0d[r%0d]", k, a), {31'b0, rd_busy[k]}, {31'b0, exp_busy(a)});
        end
        chk("probe_ack", {31'b0, probe_ack}, {31'b0, e_ack});
        chk("probe_data", probe_data, e_pdata);
        chk("clr_busy", {31'b0, clr_busy}, {31'b0, clr_left > 0});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wr0_en = 0; wr1_en = 0; iss_en = 0; clr_req = 0; probe_req = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        int clr_cycles;
        rd_addr = '0; wr0_addr = '0; wr1_addr = '0; iss_addr = '0; probe_addr = '0;
        wr0_data = '0; wr1_data = '0;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #2;
            chk("reset_rd", rd_data[31:0], 32'h0);
            chk("reset_ack", {31'b0, probe_ack}, 32'h0);
            cycle();
        end

        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        wr1_en = 1; wr1_addr = 5; wr1_data = 32'h12345678;
        cycle();
        idle_inputs(); rd_addr = {5'd5, 5'd5};
        #2 chk("wr_priority", rd_data[31:0], 32'hDEADBEEF);
        cycle();

        wr0_en = 1; wr0_addr = 7; wr0_data = 32'hA5A5A5A5; rd_addr = {5'd0, 5'd7};
`ifdef RF_BYPASS_EN
        #2 chk("bypass_r7", rd_data[31:0], 32'hA5A5A5A5);
`else
        #2 chk("nobypass_r7", rd_data[31:0], 32'h0);
`endif
        cycle();
        idle_inputs();
        #2 chk("r7_after", rd_data[31:0], 32'hA5A5A5A5);
        cycle();

        rd_addr = {5'd0, 5'd9};
        iss_en = 1; iss_addr = 9;
        cycle();
        idle_inputs();
        #2 chk("busy_r9_set", {31'b0, rd_busy[0]}, 32'h1);
        iss_en = 1; iss_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
        cycle();
        idle_inputs();
        #2 chk("busy_r9_issue_wins", {31'b0, rd_busy[0]}, 32'h1);
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h1234;
        cycle();
        idle_inputs();
        #2 chk("busy_r9_cleared", {31'b0, rd_busy[0]}, 32'h0);
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; rd_addr = {5'd0, 5'd0};
        #2 chk("r0_same", rd_data[31:0], 32'h0);
        cycle();
        idle_inputs();
        #2 chk("r0_after", rd_data[31:0], 32'h0);
        chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
        cycle();

        probe_req = 1; probe_addr = 5;
        cycle();
        cycle();
        probe_req = 0;
        #2 chk("probe_ack_pulse", {31'b0, probe_ack}, 32'h1);
        chk("probe_data_r5", probe_data, 32'hDEADBEEF);
        cycle();
        #2 chk("probe_ack_drop", {31'b0, probe_ack}, 32'h0);
        chk("probe_data_hold", probe_data, 32'hDEADBEEF);
        cycle();

        iss_en = 1; iss_addr = 12;
        clr_req = 1;
        cycle();
        idle_inputs();
        clr_cycles = 0;
        for (int i = 0; i < 36; i++) begin
            rd_addr = {5'($urandom), 5'(i)};
            if (i == 10) begin wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11111111; end
            if (i == 11) begin wr0_en = 0; clr_req = 1; end
            if (i == 12) clr_req = 0;
            #2 if (clr_busy) clr_cycles++;
            cycle();
        end
        chk("clr_cycles", 32'(clr_cycles), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(i), 5'(i)};
            #2 chk($sformatf("cleared_r%0d", i), rd_data[31:0], 32'h0);
            cycle();
        end

        wr0_en = 1; wr0_addr = 4; wr0_data = 32'hCAFE;
        cycle();
        idle_inputs(); clr_req = 1;
        cycle();
        clr_req = 0;
        for (int i = 0; i < 10; i++) cycle();
        do_reset();
        #2 chk("rst_mid_clear", {31'b0, clr_busy}, 32'h0);
        cycle();

        for (int i = 0; i < 400; i++) begin
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom)};
            wr0_en   = ($urandom % 2) == 0; wr0_addr = 5'($urandom_range(0, 7)); wr0_data = $urandom;
            wr1_en   = ($urandom % 2) == 0; wr1_addr = 5'($urandom_range(0, 7)); wr1_data = $urandom;
            iss_en   = ($urandom % 3) == 0; iss_addr = 5'($urandom_range(0, 7));
            clr_req  = ($urandom % 80) == 0;
            if (!probe_req) probe_addr = 5'($urandom);
            probe_req = ($urandom % 3) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
